mult_div_seq: RTL and testbench
===============================

MULT_DIV_SEQ -- requirements
Module: mult_div_seq

Interface
REQ-001 The block SHALL have no parameters; the datapath width is fixed at 32 bits.
REQ-002 Clock: clk, input, 1 bit; all state SHALL update on its rising edge.
REQ-003 Reset: reset, input, 1 bit; asynchronous, active-low.
REQ-004 start  input  1  request pulse from Unidade_Controle; sampled only in IDLE.
REQ-005 op  input  1  operation select: 0 = signed MULT, 1 = signed DIV.
REQ-006 a  input  32  multiplicand or dividend (RegA_out).
REQ-007 b  input  32  multiplier or divisor (RegB_out).
REQ-008 busy  output  1  high while an operation is in progress (any state other than IDLE).
REQ-009 done  output  1  one-cycle pulse; hi and lo are valid and updated in the same cycle.
REQ-010 div_zero  output  1  one-cycle pulse flagging a DIV with b = 0.
REQ-011 hi  output  32  HI register (product[63:32] or remainder).
REQ-012 lo  output  32  LO register (product[31:0] or quotient).

Function
REQ-013 The FSM SHALL have five states: IDLE, MULT, DIV, FIX, DONE.
REQ-014 IDLE, start=1, op=0 -> MULT.
- Operands SHALL be latched internally at this edge (edge N).
- The iteration counter SHALL be loaded with 32.
REQ-015 IDLE, start=1, op=1, b≠0 -> DIV, with operand latch and counter load as in REQ-014.
REQ-016 IDLE, start=1, op=1, b=0:
- The FSM SHALL stay in IDLE.
- div_zero SHALL be high in cycle N+1.
- hi, lo and busy SHALL remain unchanged / low.
REQ-017 MULT SHALL perform radix-2 Booth iterations, one per clock, on a 65-bit {acc, q, q-1} register with arithmetic right shift.
REQ-018 MULT SHALL transition to DONE after 32 iterations.
REQ-019 DIV SHALL perform restoring division, one iteration per clock, on operand magnitudes.
REQ-020 DIV SHALL transition to FIX after 32 iterations.
REQ-021 FIX (one cycle) SHALL apply sign correction:
- quotient negated if sign(a) XOR sign(b);
- remainder negated if sign(a);
- the remainder sign always follows the dividend.
REQ-022 DONE (one cycle): hi/lo SHALL be written, done=1, then the FSM returns to IDLE.
REQ-023 MULT latency: done SHALL be high in cycle N+33.
REQ-024 DIV latency: done SHALL be high in cycle N+34.
REQ-025 busy SHALL be high from cycle N+1 through the DONE cycle inclusive.
REQ-026 start asserted while busy=1 SHALL be ignored, with no queuing.
REQ-027 start sampled in the same edge as the DONE→IDLE transition SHALL be ignored; a new start is accepted only in IDLE.
REQ-028 hi/lo SHALL change only in DONE; between operations they hold their values.
REQ-029 Changes on a or b after edge N SHALL NOT affect the result in progress.
REQ-030 Overflow case 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000, hi=0x00000000, with no flag raised.
REQ-031 MULT arithmetic is two's-complement 64-bit; no overflow is possible and none SHALL be flagged.
REQ-032 done and div_zero SHALL never be high in the same cycle.

Reset
REQ-033 reset=0 SHALL immediately force, regardless of clk:
- state = IDLE;
- busy = 0, done = 0, div_zero = 0;
- hi = lo = 0x00000000;
- iteration counter = 0.
REQ-034 Reset asserted mid-operation SHALL abort the operation with no partial update of hi/lo.
REQ-035 The first start SHALL be accepted on the first rising edge after reset deasserts.

Verification
REQ-036 MULT a=7, b=0xFFFFFFFD (-3) -> done at N+33; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high for cycles N+1..N+33.
REQ-037 MULT a=b=0x7FFFFFFF -> hi=0x3FFFFFFF, lo=0x00000001.
REQ-038 DIV a=0xFFFFFFF9 (-7), b=2 -> done at N+34; lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
REQ-039 DIV a=5, b=0 -> div_zero=1 at N+1 only; done and busy stay 0; hi/lo retain their prior values.
REQ-040 DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0; then start pulses at N+5 during busy -> no effect, single done pulse.
REQ-041 Reset at N+10 of a MULT -> busy=0 and hi=lo=0 immediately; a new MULT 3×4 started after release -> lo=12, hi=0 at its N+33.

Source files
------------

// File: rtl/mult_div_seq.sv
// Sequential signed 32x32 multiply (radix-2 Booth) and signed divide (restoring).
// One iteration per clock; hi/lo are updated only when the result is presented.
module mult_div_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic        div_zero,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_MULT = 3'd1;
    localparam logic [2:0] S_DIV  = 3'd2;
    localparam logic [2:0] S_FIX  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]  r_state;
    logic [5:0]  r_cnt;
    logic [32:0] r_acc;
    logic [31:0] r_q;
    logic        r_q1;
    logic [32:0] r_m;
    logic        r_neg_q;
    logic        r_neg_r;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_div_zero;

    logic [32:0] w_booth_sum;
    logic [32:0] w_booth_acc;
    logic [31:0] w_booth_q;
    logic [32:0] w_rem_sh;
    logic [32:0] w_diff;
    logic [32:0] w_div_acc;
    logic [31:0] w_div_q;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [31:0] w_quo_fix;
    logic [31:0] w_rem_fix;
    logic        w_last;

    // Accumulator carries one guard bit so acc - M cannot overflow when M = -2^31.
    always_comb begin
        w_booth_sum = r_acc;
        case ({r_q[0], r_q1})
            2'b01:   w_booth_sum = r_acc + r_m;
            2'b10:   w_booth_sum = r_acc - r_m;
            default: w_booth_sum = r_acc;
        endcase
        w_booth_acc = {w_booth_sum[32], w_booth_sum[32:1]};
        w_booth_q   = {w_booth_sum[0], r_q[31:1]};
    end

    // Restoring step: partial remainder and divisor are both below 2^32,
    // so bit 32 of the difference is a reliable "went negative" flag.
    always_comb begin
        w_rem_sh  = {r_acc[31:0], r_q[31]};
        w_diff    = w_rem_sh - r_m;
        w_div_acc = w_diff[32] ? w_rem_sh : w_diff;
        w_div_q   = {r_q[30:0], ~w_diff[32]};
    end

    always_comb begin
        w_abs_a   = a[31] ? (~a + 32'd1) : a;
        w_abs_b   = b[31] ? (~b + 32'd1) : b;
        w_quo_fix = r_neg_q ? (~r_q + 32'd1) : r_q;
        w_rem_fix = r_neg_r ? (~r_acc[31:0] + 32'd1) : r_acc[31:0];
        w_last    = (r_cnt == 6'd1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_q        <= '0;
            r_q1       <= 1'b0;
            r_m        <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_div_zero <= 1'b0;
        end else begin
            r_div_zero <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (!op) begin
                            r_state <= S_MULT;
                            r_cnt   <= 6'd32;
                            r_acc   <= '0;
                            r_q     <= a;
                            r_q1    <= 1'b0;
                            r_m     <= {b[31], b};
                        end else if (b == '0) begin
                            r_div_zero <= 1'b1;
                        end else begin
                            r_state <= S_DIV;
                            r_cnt   <= 6'd32;
                            r_acc   <= '0;
                            r_q     <= w_abs_a;
                            r_q1    <= 1'b0;
                            r_m     <= {1'b0, w_abs_b};
                            r_neg_q <= a[31] ^ b[31];
                            r_neg_r <= a[31];
                        end
                    end
                end
                S_MULT: begin
                    r_acc <= w_booth_acc;
                    r_q   <= w_booth_q;
                    r_q1  <= r_q[0];
                    r_cnt <= r_cnt - 6'd1;
                    if (w_last) begin
                        r_hi    <= w_booth_acc[31:0];
                        r_lo    <= w_booth_q;
                        r_state <= S_DONE;
                    end
                end
                S_DIV: begin
                    r_acc <= w_div_acc;
                    r_q   <= w_div_q;
                    r_cnt <= r_cnt - 6'd1;
                    if (w_last) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_hi    <= w_rem_fix;
                    r_lo    <= w_quo_fix;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        busy     = (r_state != S_IDLE);
        done     = (r_state == S_DONE);
        div_zero = r_div_zero;
        hi       = r_hi;
        lo       = r_lo;
    end

endmodule

// File: tb/tb_mult_div_seq.sv
// Self-checking bench for mult_div_seq: directed corner cases plus random
// operations compared against 64-bit integer arithmetic.
module tb_mult_div_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int unsigned errors = 0;
    int unsigned checks = 0;

    mult_div_seq dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {hi, lo}: product for MULT; {remainder, quotient} truncated toward zero for DIV.
    function automatic logic [63:0] ref_res(input logic o, input logic [31:0] x, input logic [31:0] y);
        longint sx;
        longint sy;
        longint p;
        longint qq;
        longint rr;
        sx = $signed(x);
        sy = $signed(y);
        if (!o) begin
            p = sx * sy;
            return p;
        end
        qq = sx / sy;
        rr = sx % sy;
        return {rr[31:0], qq[31:0]};
    endfunction

    // Caller is mid-cycle; the next rising edge is edge N. Optionally pulses
    // start during cycle N+pulse_k (0 = never).
    task automatic run_op(input string tag, input logic o, input logic [31:0] x,
                          input logic [31:0] y, input int unsigned pulse_k);
        logic [63:0] exp_r;
        logic [63:0] prev;
        logic [63:0] got;
        int unsigned lat;
        int unsigned first_done;
        int unsigned n_done;
        int unsigned busy_bad;
        int unsigned dz_seen;
        int unsigned hold_bad;
        exp_r      = ref_res(o, x, y);
        lat        = o ? 34 : 33;
        prev       = {hi, lo};
        got        = prev;
        first_done = 0;
        n_done     = 0;
        busy_bad   = 0;
        dz_seen    = 0;
        hold_bad   = 0;
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        op    = 1'($urandom_range(0, 1));
        for (int unsigned k = 1; k <= 40; k++) begin
            if (busy !== (k <= lat)) busy_bad++;
            if (done === 1'b1) begin
                n_done++;
                if (first_done == 0) first_done = k;
                got = {hi, lo};
            end
            if (div_zero !== 1'b0) dz_seen++;
            if (k < lat && {hi, lo} !== prev) hold_bad++;
            start = (k == pulse_k);
            @(posedge clk); #1;
        end
        start = 1'b0;
        chk({tag, "_latency"}, 64'(first_done), 64'(lat));
        chk({tag, "_ndone"},   64'(n_done),     64'd1);
        chk({tag, "_busy"},    64'(busy_bad),   64'd0);
        chk({tag, "_dzflag"},  64'(dz_seen),    64'd0);
        chk({tag, "_hold"},    64'(hold_bad),   64'd0);
        chk({tag, "_result"},  got,             exp_r);
        chk({tag, "_after"},   {hi, lo},        exp_r);
    endtask

    task automatic run_divzero(input string tag, input logic [31:0] x);
        logic [63:0] prev;
        prev  = {hi, lo};
        op    = 1'b1;
        a     = x;
        b     = '0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, "_dz_n1"},   {63'd0, div_zero}, 64'd1);
        chk({tag, "_busy_n1"}, {63'd0, busy},     64'd0);
        chk({tag, "_done_n1"}, {63'd0, done},     64'd0);
        chk({tag, "_hilo_n1"}, {hi, lo},          prev);
        @(posedge clk); #1;
        chk({tag, "_dz_n2"},   {62'd0, div_zero, done}, 64'd0);
        chk({tag, "_busy_n2"}, {63'd0, busy},           64'd0);
        chk({tag, "_hilo_n2"}, {hi, lo},                prev);
    endtask

    initial begin
        logic        o;
        logic [31:0] x;
        logic [31:0] y;
        reset = 1'b0;
        start = 1'b0;
        op    = 1'b0;
        a     = '0;
        b     = '0;
        #2;
        chk("rst_async_flags", {61'd0, busy, done, div_zero}, 64'd0);
        chk("rst_async_hilo",  {hi, lo},                      64'd0);
        @(posedge clk); #1;
        chk("rst_clocked_flags", {61'd0, busy, done, div_zero}, 64'd0);

        @(negedge clk);
        reset = 1'b1;
        run_op("mul_7x-3", 1'b0, 32'd7, 32'hFFFF_FFFD, 0);
        chk("mul_7x-3_exact", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op("mul_max", 1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 0);
        chk("mul_max_exact", {hi, lo}, 64'h3FFF_FFFF_0000_0001);
        run_op("div_-7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 0);
        chk("div_-7/2_exact", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_divzero("dz_5", 32'd5);
        run_op("div_ovf_pulse", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5);
        chk("div_ovf_exact", {hi, lo}, 64'h0000_0000_8000_0000);
        run_op("mul_min_min", 1'b0, 32'h8000_0000, 32'h8000_0000, 0);
        run_op("mul_min_1", 1'b0, 32'h0000_0001, 32'h8000_0000, 0);
        run_op("mul_min_by1", 1'b0, 32'h8000_0000, 32'h0000_0001, 33);
        run_op("div_7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 34);
        run_op("div_min/1", 1'b1, 32'h8000_0000, 32'd1, 0);
        run_op("div_small_big", 1'b1, 32'd3, 32'h7FFF_FFFF, 0);

        // Reset in the middle of a MULT: outputs clear without waiting for a clock.
        op    = 1'b0;
        a     = 32'h1234_5678;
        b     = 32'h0000_0ABC;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int unsigned k = 1; k < 10; k++) begin
            @(posedge clk); #1;
        end
        chk("pre_rst_busy", {63'd0, busy}, 64'd1);
        reset = 1'b0;
        #1;
        chk("midrst_flags", {61'd0, busy, done, div_zero}, 64'd0);
        chk("midrst_hilo",  {hi, lo},                      64'd0);
        @(negedge clk);
        reset = 1'b1;
        run_op("mul_3x4", 1'b0, 32'd3, 32'd4, 0);
        chk("mul_3x4_exact", {hi, lo}, 64'd12);

        for (int i = 0; i < 24; i++) begin
            o = 1'($urandom_range(0, 1));
            x = $urandom;
            y = $urandom;
            if (i % 3 == 0) y = $urandom_range(0, 15) - 32'd8;
            if (o && y == '0) y = 32'd1;
            run_op($sformatf("rand%0d", i), o, x, y, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
